// File: rtl/mem_pkg.sv
// Shared types and defaults for the word memory responder.
// The error rule lives here so the top and any checker use one definition.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_LATENCY     = 2;
   localparam int CNT_W               = 4;

   // A request is rejected when misaligned, beyond the last word (no wrap), or both read and write.
   function automatic logic req_error(input logic [31:0] addr, input logic rd, input logic wr,
                                      input int depth);
      logic [31:0] word_idx;
      word_idx = {2'b00, addr[31:2]};
      return (addr[1:0] != 2'b00) || (word_idx >= 32'(depth)) || (rd && wr);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Multicycle-core memory responder: accepts one request in IDLE, waits LATENCY
// cycles, then pulses ready (and err on a bad request) for one cycle.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int LATENCY     = DEFAULT_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        memread,
   input  logic        memwrite,
   output logic [31:0] readData,
   output logic        ready,
   output logic        err,
   output state_t      fsm_state
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // Handshake: a request is taken at a rising edge in IDLE while memread or memwrite is 1;
   // the requester may then change or drop its inputs. ready (with err) is a single-cycle
   // completion strobe; readData stays valid from that strobe until the next good read.
   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [AW-1:0]     word_q;
   logic [31:0]       wdata_q;
   logic              wr_q;
   logic              bad_q;
   logic              accept, finish, ram_we;
   logic [31:0]       ram_rdata;
   logic [31:0]       rdata_q;
   logic              ready_q, err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (memread || memwrite) state_next = BUSY;
         BUSY:    if (cnt == '0)           state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fsm_state = state;
      accept    = (state == IDLE) && (memread || memwrite);
      finish    = (state == BUSY) && (cnt == '0);
      ram_we    = finish && wr_q && !bad_q;
   end

   // Request capture and wait counter; the error verdict is decided once, at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
      end else if (accept) begin
         cnt     <= CNT_W'(LATENCY - 1);
         word_q  <= address[AW+1:2];
         wdata_q <= writeData;
         wr_q    <= memwrite && !memread;
         bad_q   <= req_error(address, memread, memwrite, DEPTH_WORDS);
      end else if ((state == BUSY) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= (state == RESP);
         err_q   <= (state == RESP) && bad_q;
         if (finish) begin
            if (bad_q)      rdata_q <= '0;
            else if (!wr_q) rdata_q <= ram_rdata;
         end
      end
   end

   mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (word_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign readData = rdata_q;
   assign ready    = ready_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array model
// with an expected-readData queue.
module tb_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic               clk;
   logic               rst_n;
   logic [31:0]        address;
   logic [31:0]        writeData;
   logic               memread;
   logic               memwrite;
   logic [31:0]        readData;
   logic               ready;
   logic               err;
   mem_pkg::state_t    fsm_state;

   int          vectors;
   int          miscompares;
   logic [31:0] model [DEPTH];
   logic [31:0] model_rdata;
   logic [31:0] exp_q [$];

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .address   (address),
      .writeData (writeData),
      .memread   (memread),
      .memwrite  (memwrite),
      .readData  (readData),
      .ready     (ready),
      .err       (err),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Start at a negedge with the responder idle (or in its completion cycle).
   task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
      logic        bad;
      int          lat;
      logic [31:0] exp_rd;
      bad = (addr % 4 != 0) || ((addr / 4) >= DEPTH) || (rd && wr);
      if (bad)     model_rdata = 32'h0;
      else if (rd) model_rdata = model[int'(addr / 4)];
      if (!bad && wr) model[int'(addr / 4)] = data;
      exp_q.push_back(model_rdata);
      memread   = rd;
      memwrite  = wr;
      address   = addr;
      writeData = data;
      @(posedge clk);
      @(negedge clk);
      memread   = 1'b0;
      memwrite  = 1'b0;
      address   = $urandom;
      writeData = $urandom;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (ready) begin
            lat = k;
            break;
         end
      end
      check_eq("ready_latency", 32'(lat), 32'(LAT + 2));
      check_eq("err", {31'b0, err}, {31'b0, bad});
      exp_rd = exp_q.pop_front();
      check_eq("readData", readData, exp_rd);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_rdata = 32'h0;
      rst_n       = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      address     = 32'h0;
      writeData   = 32'h0;
      #12;
      check_eq("reset_ready", {31'b0, ready}, 32'h0);
      check_eq("reset_err", {31'b0, err}, 32'h0);
      check_eq("reset_readData", readData, 32'h0);
      check_eq("reset_state", 32'(fsm_state), 32'(mem_pkg::IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 1'b1, 32'(i * 4), $urandom);

      // directed cases
      do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      do_txn(1'b1, 1'b0, 32'h10, $urandom);
      do_txn(1'b1, 1'b0, 32'h13, $urandom);
      do_txn(1'b1, 1'b0, 32'h10, $urandom);
      do_txn(1'b0, 1'b1, 32'h400, $urandom);
      do_txn(1'b1, 1'b0, 32'h0, $urandom);
      do_txn(1'b1, 1'b1, 32'h20, $urandom);
      do_txn(1'b1, 1'b0, 32'h20, $urandom);
      do_txn(1'b0, 1'b1, 32'h20, 32'h12345678);
      do_txn(1'b1, 1'b0, 32'h20, $urandom);
      do_txn(1'b1, 1'b0, 32'hFFFFFFFC, $urandom);

      // reset while a write is in flight
      do_txn(1'b1, 1'b0, 32'h30, $urandom);
      memread   = 1'b0;
      memwrite  = 1'b1;
      address   = 32'h30;
      writeData = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      memwrite = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_eq("abort_ready", {31'b0, ready}, 32'h0);
      check_eq("abort_readData", readData, 32'h0);
      model_rdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("abort_state", 32'(fsm_state), 32'(mem_pkg::IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(1'b1, 1'b0, 32'h30, $urandom);

      // random traffic
      for (int n = 0; n < 80; n++) begin
         logic        rd, wr;
         logic [31:0] a;
         int          sel;
         sel = $urandom_range(0, 9);
         rd  = $urandom_range(0, 1) == 1;
         wr  = !rd;
         if ($urandom_range(0, 15) == 0) begin
            rd = 1'b1;
            wr = 1'b1;
         end
         if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else               a = 32'($urandom_range(DEPTH, 1 << 20) * 4);
         do_txn(rd, wr, a, $urandom);
      end

      // full readback: catches any stray or wrapped write
      for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 1'b0, 32'(i * 4), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, 4..4096.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request accept and response; range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  32  byte address from the multicycle core.
REQ-006 SHALL have port writeData  input  32  store data.
REQ-007 SHALL have port memread  input  1  read request.
REQ-008 SHALL have port memwrite  input  1  write request.
REQ-009 SHALL have port readData  output  32  load data, valid while ready=1 for a read, then held.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP; IDLE->BUSY on accept; BUSY->RESP when wait counter reaches 0; RESP->IDLE unconditionally.
REQ-013 SHALL accept a request only in IDLE, at a rising edge where memread or memwrite is 1; address, writeData and operation latched at that edge.
REQ-014 SHALL ignore all request inputs in BUSY and RESP; inputs changing after accept have no effect.
REQ-015 SHALL load wait counter with LATENCY-1 on accept, decrement each BUSY cycle; ready=1 exactly during the cycle after edge E0+LATENCY+1, E0 = accept edge.
REQ-016 SHALL commit a write to word address[log2(DEPTH_WORDS)+1:2] at the BUSY->RESP edge.
REQ-017 SHALL present read word on readData at the BUSY->RESP edge and hold it until the next successful read completes.
REQ-018 SHALL flag err, perform no write, and drive readData=0 when address[1:0]!=0 (misaligned).
REQ-019 SHALL flag err, perform no write, and drive readData=0 when address[31:2] >= DEPTH_WORDS (out of range; no wrap).
REQ-020 SHALL treat memread=1 and memwrite=1 at the same accept edge as an error: no access, err=1, readData=0.
REQ-021 SHALL treat a request still asserted in the IDLE cycle following RESP as a new request (back-to-back allowed; minimum 1 IDLE cycle between transactions).
REQ-022 SHALL keep read-after-write consistent: a read accepted after a write's ready returns the written data.

Reset
REQ-023 SHALL on rst_n=0 force state=IDLE, counter=0, ready=0, err=0, readData=0, asynchronously.
REQ-024 SHALL abort any in-flight transaction on reset mid-operation; an aborted write SHALL NOT modify storage.
REQ-025 SHALL NOT reset the storage array contents.

Structure
REQ-026 SHALL place FSM state enum and default DEPTH_WORDS/LATENCY constants in shared package mem_pkg.
REQ-027 SHALL instantiate one sub-module mem_array: synchronous single-port word RAM, 1-cycle write, combinational-or-registered read hidden by LATENCY>=1.

Verification
REQ-028 Write 0xDEADBEEF to 0x10, LATENCY=2 -> ready pulses 3 cycles after accept, err=0; then read 0x10 -> readData=0xDEADBEEF with ready.
REQ-029 Read 0x13 (misaligned) -> ready=1, err=1, readData=0; subsequent read of 0x10 returns 0xDEADBEEF.
REQ-030 Write to 0x400 with DEPTH_WORDS=256 -> err=1; read 0x000 unchanged (no wrap).
REQ-031 memread=memwrite=1 at 0x20 -> err=1, word at 0x20 unchanged.
REQ-032 Write 0x12345678 to 0x20, toggle address/writeData during BUSY -> only 0x20 holds 0x12345678.
REQ-033 Accept write 0xCAFEF00D to 0x30, assert rst_n=0 in BUSY -> ready=0, readData=0 immediately; after release, read 0x30 returns prior value.
